// File: rtl/exe_wb_sched_pkg.sv
// exe_wb_sched_pkg: shared types and constants for the writeback scheduler.
//   ALU_LATENCY / FPU_LATENCY / FDIV_LATENCY : issue-to-writeback cycles per unit
//   RegFile_t  : destination register {class, index}
//   ExeUnit_t  : execution unit selector
//   ExeBusy_t  : per-unit issue inhibit vector
//   WbSlot_t   : one writeback reservation {valid, rd, iq_id, unit}
package exe_wb_sched_pkg;

   localparam int unsigned ALU_LATENCY   = 1;
   localparam int unsigned FPU_LATENCY   = 4;
   localparam int unsigned FDIV_LATENCY  = 16;
   localparam int unsigned IQ_DEPTH_DFLT = 16;
   // iq_id storage width inside a slot; must cover $clog2(IQ_DEPTH)
   localparam int unsigned IQ_W_MAX      = 8;

   // active-low enable levels and the plain inactive level
   localparam logic ENABLE_N  = 1'b0;
   localparam logic DISABLE_N = 1'b1;
   localparam logic DISABLE   = 1'b0;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_ARCH = 2'd1,
      REG_ROB  = 2'd2
   } RegType_t;

   typedef struct packed {
      RegType_t   rtype;
      logic [4:0] addr;
   } RegFile_t;

   typedef enum logic [2:0] {
      UNIT_NOP  = 3'd0,
      UNIT_ALU  = 3'd1,
      UNIT_FPU  = 3'd2,
      UNIT_FDIV = 3'd3,
      UNIT_LSU  = 3'd4
   } ExeUnit_t;

   typedef struct packed {
      logic lsu;
      logic fdiv;
      logic fpu;
      logic alu;
   } ExeBusy_t;

   typedef struct packed {
      logic                valid;
      RegFile_t            rd;
      logic [IQ_W_MAX-1:0] iq_id;
      ExeUnit_t            unit;
   } WbSlot_t;

   // 0 means the unit produces no writeback
   function automatic int unsigned unit_latency(ExeUnit_t u, int unsigned fpu_lat,
                                                int unsigned fdiv_lat);
      case (u)
         UNIT_ALU:  return ALU_LATENCY;
         UNIT_FPU:  return fpu_lat;
         UNIT_FDIV: return fdiv_lat;
         default:   return 0;
      endcase
   endfunction

endpackage

// File: rtl/exe_wb_sched_slot_line.sv
// wb_slot_line: writeback reservation shift line slot[1..DEPTH].
// Every edge the line advances one place toward slot[1]; an insert lands at
// slot[ins_idx] after the shift. Flush clears every entry.
//   clk, reset_   : clock, asynchronous active-low reset
//   flush_        : synchronous active-low flush
//   ins_valid     : write ins_data into slot[ins_idx] this edge
//   ins_idx       : target slot index (1..DEPTH)
//   ins_data      : reservation to store
//   head          : slot[1], the reservation writing back next cycle
//   tap_valid     : slot[TAP].valid
module wb_slot_line
   import exe_wb_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 15,
   parameter int unsigned TAP   = 4,
   localparam int unsigned IW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          flush_,
   input  logic          ins_valid,
   input  logic [IW-1:0] ins_idx,
   input  WbSlot_t       ins_data,
   output WbSlot_t       head,
   output logic          tap_valid
);

   WbSlot_t slot [1:DEPTH];

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int unsigned k = 1; k <= DEPTH; k++) slot[k] <= '0;
      end else if (flush_ == ENABLE_N) begin
         for (int unsigned k = 1; k <= DEPTH; k++) slot[k] <= '0;
      end else begin
         for (int unsigned k = 1; k < DEPTH; k++) slot[k] <= slot[k+1];
         slot[DEPTH] <= '0;
         // later assignment wins over the shift into the same index
         if (ins_valid) slot[ins_idx] <= ins_data;
      end
   end

   assign head      = slot[1];
   assign tap_valid = slot[TAP].valid;

endmodule

// File: rtl/exe_wb_sched.sv
// exe_wb_sched: reserves a unique writeback slot for each issued ALU/FPU/FDIV
// instruction at its fixed latency and drives the writeback at that cycle.
//   clk, reset_  : clock, asynchronous active-low reset
//   flush_       : synchronous active-low flush (drops pending work)
//   issue_e_     : issue valid, active-low
//   issue_iq_id  : issue queue id of the issued instruction
//   issue_rd     : destination register
//   issue_unit   : target execution unit
//   exe_busy     : per-unit issue inhibit, from registered state only
//   wb_e_        : writeback valid, active-low
//   wb_rd        : writeback destination register
//   wb_iq_id     : issue queue id of the writeback
//   wb_unit      : unit producing the writeback
module exe_wb_sched
   import exe_wb_sched_pkg::*;
#(
   parameter int unsigned FPU_LAT  = FPU_LATENCY,
   parameter int unsigned FDIV_LAT = FDIV_LATENCY,
   parameter int unsigned IQ_DEPTH = IQ_DEPTH_DFLT,
   localparam int unsigned IQ      = $clog2(IQ_DEPTH)
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          flush_,
   input  logic          issue_e_,
   input  logic [IQ-1:0] issue_iq_id,
   input  RegFile_t      issue_rd,
   input  ExeUnit_t      issue_unit,
   output ExeBusy_t      exe_busy,
   output logic          wb_e_,
   output RegFile_t      wb_rd,
   output logic [IQ-1:0] wb_iq_id,
   output ExeUnit_t      wb_unit
);

   localparam int unsigned DEPTH = FDIV_LAT - 1;
   localparam int unsigned IW    = $clog2(FDIV_LAT);

   int unsigned   lat;
   logic          unit_busy;
   logic          issue_req;
   logic          issue_ok;
   logic          ins_valid;
   logic [IW-1:0] ins_idx;
   WbSlot_t       new_slot;
   WbSlot_t       head;
   logic          fpu_tap;
   logic [IW-1:0] div_cnt;
   WbSlot_t       wb_q;
   logic [IQ_W_MAX-1:0] unused_iq;

   always_comb begin
      lat       = unit_latency(issue_unit, FPU_LAT, FDIV_LAT);
      unit_busy = 1'b0;
      case (issue_unit)
         UNIT_ALU:  unit_busy = exe_busy.alu;
         UNIT_FPU:  unit_busy = exe_busy.fpu;
         UNIT_FDIV: unit_busy = exe_busy.fdiv;
         default:   unit_busy = 1'b0;
      endcase
      issue_req = (issue_e_ == ENABLE_N) && (flush_ == DISABLE_N) && (lat != 0);
      issue_ok  = issue_req && !unit_busy;
      ins_valid = issue_ok && (lat > 1);
      ins_idx   = IW'(lat - 1);

      new_slot       = '0;
      new_slot.valid = 1'b1;
      new_slot.rd    = issue_rd;
      new_slot.iq_id = IQ_W_MAX'(issue_iq_id);
      new_slot.unit  = issue_unit;
   end

   wb_slot_line #(
      .DEPTH (DEPTH),
      .TAP   (FPU_LAT)
   ) u_line (
      .clk       (clk),
      .reset_    (reset_),
      .flush_    (flush_),
      .ins_valid (ins_valid),
      .ins_idx   (ins_idx),
      .ins_data  (new_slot),
      .head      (head),
      .tap_valid (fpu_tap)
   );

   // FDIV is unpipelined: occupied for FDIV_LAT-1 cycles after issue
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         div_cnt <= '0;
      end else if (flush_ == ENABLE_N) begin
         div_cnt <= '0;
      end else if (issue_ok && issue_unit == UNIT_FDIV) begin
         div_cnt <= IW'(FDIV_LAT - 1);
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   // ALU issue bypasses the line; it can never coincide with a valid head
   // because exe_busy.alu blocks it in exactly that cycle.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wb_q       <= '0;
         wb_q.unit  <= UNIT_NOP;
      end else if (flush_ == ENABLE_N) begin
         wb_q.valid <= 1'b0;
      end else if (issue_ok && lat == 1) begin
         wb_q       <= new_slot;
      end else begin
         wb_q       <= head;
      end
   end

   always_comb begin
      exe_busy      = '0;
      exe_busy.alu  = head.valid;
      exe_busy.fpu  = fpu_tap;
      exe_busy.fdiv = (div_cnt != '0);
      exe_busy.lsu  = DISABLE;
   end

   assign wb_e_     = wb_q.valid ? ENABLE_N : DISABLE_N;
   assign wb_rd     = wb_q.rd;
   assign wb_iq_id  = wb_q.iq_id[IQ-1:0];
   assign wb_unit   = wb_q.unit;
   assign unused_iq = wb_q.iq_id;

   // Issuing into a busy unit is a protocol violation; the issue is dropped.
   a_no_busy_issue: assert property (@(posedge clk) disable iff (!reset_)
                                     issue_req |-> !unit_busy);

endmodule

// File: tb/tb_exe_wb_sched.sv
module tb_exe_wb_sched;
   import exe_wb_sched_pkg::*;

   localparam int unsigned L_ALU  = 1;
   localparam int unsigned L_FPU  = 4;
   localparam int unsigned L_FDIV = 16;

   logic       clk = 1'b0;
   logic       reset_;
   logic       flush_;
   logic       issue_e_;
   logic [3:0] issue_iq_id;
   RegFile_t   issue_rd;
   ExeUnit_t   issue_unit;
   ExeBusy_t   exe_busy;
   logic       wb_e_;
   RegFile_t   wb_rd;
   logic [3:0] wb_iq_id;
   ExeUnit_t   wb_unit;

   exe_wb_sched dut (
      .clk         (clk),
      .reset_      (reset_),
      .flush_      (flush_),
      .issue_e_    (issue_e_),
      .issue_iq_id (issue_iq_id),
      .issue_rd    (issue_rd),
      .issue_unit  (issue_unit),
      .exe_busy    (exe_busy),
      .wb_e_       (wb_e_),
      .wb_rd       (wb_rd),
      .wb_iq_id    (wb_iq_id),
      .wb_unit     (wb_unit)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      RegFile_t    rd;
      logic [3:0]  iq;
      ExeUnit_t    unit;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // monitor: compares each presented writeback against the reservation due now
   always @(negedge clk) begin : mon
      int idx;
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL wb_missing rd=%0h due cyc %0d, now %0d", sb[i].rd, sb[i].cyc, cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
      if (wb_e_ === 1'b0) begin
         idx = -1;
         for (int j = 0; j < sb.size(); j++)
            if (sb[j].cyc == cyc && idx < 0) idx = j;
         total++;
         if (idx < 0) begin
            bad++;
            $display("FAIL wb_unexpected @cyc %0d: rd=%0h iq=%0h unit=%0d", cyc, wb_rd, wb_iq_id, wb_unit);
         end else begin
            if (wb_rd !== sb[idx].rd || wb_iq_id !== sb[idx].iq || wb_unit !== sb[idx].unit) begin
               bad++;
               $display("FAIL wb_data @cyc %0d: got rd=%0h iq=%0h unit=%0d exp rd=%0h iq=%0h unit=%0d",
                        cyc, wb_rd, wb_iq_id, wb_unit, sb[idx].rd, sb[idx].iq, sb[idx].unit);
            end
            sb.delete(idx);
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drives one issue for a single cycle; expect_wb pushes the reservation
   task automatic issue(input ExeUnit_t u, input RegType_t rt, input int unsigned a,
                        input int unsigned iq, input int unsigned lat, input bit expect_wb);
      exp_t e;
      issue_e_    = 1'b0;
      issue_unit  = u;
      issue_rd    = '{rtype: rt, addr: 5'(a)};
      issue_iq_id = 4'(iq);
      if (expect_wb) begin
         e.cyc  = cyc + lat;
         e.rd   = '{rtype: rt, addr: 5'(a)};
         e.iq   = 4'(iq);
         e.unit = u;
         sb.push_back(e);
      end
      tick(1);
      issue_e_   = 1'b1;
      issue_unit = UNIT_NOP;
   endtask

   initial begin
      reset_      = 1'b0;
      flush_      = 1'b1;
      issue_e_    = 1'b1;
      issue_iq_id = '0;
      issue_rd    = '{rtype: REG_NONE, addr: 5'd0};
      issue_unit  = UNIT_NOP;
      tick(3);
      reset_ = 1'b1;
      tick(1);

      // reset state
      check("rst_wb_e", 32'(wb_e_), 32'd1);
      check("rst_busy", 32'(exe_busy), 32'd0);
      check("rst_unit", 32'(wb_unit), 32'(UNIT_NOP));
      check("rst_rd", 32'(wb_rd), 32'd0);

      // single ALU issue
      issue(UNIT_ALU, REG_ROB, 2, 1, L_ALU, 1'b1);
      tick(2);

      // FPU then ALU blocked exactly one cycle before FPU writeback
      issue(UNIT_FPU, REG_ROB, 3, 2, L_FPU, 1'b1);
      check("alu_busy_t1", 32'(exe_busy.alu), 32'd0);
      tick(1);
      check("alu_busy_t2", 32'(exe_busy.alu), 32'd0);
      tick(1);
      check("alu_busy_t3", 32'(exe_busy.alu), 32'd1);
      tick(1);
      check("alu_busy_t4", 32'(exe_busy.alu), 32'd0);
      issue(UNIT_ALU, REG_ARCH, 8, 3, L_ALU, 1'b1);
      tick(3);

      // back-to-back FPU issues
      for (int i = 0; i < 4; i++) begin
         check("fpu_busy_b2b", 32'(exe_busy.fpu), 32'd0);
         issue(UNIT_FPU, REG_ROB, 4 + i, i, L_FPU, 1'b1);
      end
      tick(6);

      // FDIV occupancy and back-to-back FDIV at the earliest legal cycle
      issue(UNIT_FDIV, REG_ROB, 9, 5, L_FDIV, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         check("fdiv_busy", 32'(exe_busy.fdiv), (k <= 15) ? 32'd1 : 32'd0);
         if (k < 16) tick(1);
      end
      issue(UNIT_FDIV, REG_ROB, 10, 6, L_FDIV, 1'b1);
      tick(18);

      // FPU blocked where it would collide with an FDIV writeback
      issue(UNIT_FDIV, REG_ROB, 11, 7, L_FDIV, 1'b1);
      tick(11);
      check("fpu_busy_vs_fdiv", 32'(exe_busy.fpu), 32'd1);
      tick(1);
      check("fpu_free_after", 32'(exe_busy.fpu), 32'd0);
      issue(UNIT_FPU, REG_ROB, 12, 8, L_FPU, 1'b1);
      tick(6);

      // units without a writeback are ignored
      issue(UNIT_LSU, REG_ROB, 20, 9, 1, 1'b0);
      issue(UNIT_NOP, REG_ROB, 21, 10, 1, 1'b0);
      check("ignored_busy", 32'(exe_busy), 32'd0);
      tick(3);

      // flush drops the pending FPU and a same-cycle ALU issue
      issue(UNIT_FPU, REG_ROB, 13, 11, L_FPU, 1'b0);
      tick(1);
      flush_      = 1'b0;
      issue_e_    = 1'b0;
      issue_unit  = UNIT_ALU;
      issue_rd    = '{rtype: REG_ROB, addr: 5'd14};
      issue_iq_id = 4'd12;
      tick(1);
      flush_     = 1'b1;
      issue_e_   = 1'b1;
      issue_unit = UNIT_NOP;
      check("flush_no_alu_wb", 32'(wb_e_), 32'd1);
      tick(1);
      check("flush_no_fpu_wb", 32'(wb_e_), 32'd1);
      tick(2);

      // reset mid-divide
      issue(UNIT_FDIV, REG_ROB, 15, 13, L_FDIV, 1'b0);
      tick(4);
      check("fdiv_busy_pre_rst", 32'(exe_busy.fdiv), 32'd1);
      reset_ = 1'b0;
      #1;
      check("fdiv_busy_in_rst", 32'(exe_busy.fdiv), 32'd0);
      tick(2);
      reset_ = 1'b1;
      tick(20);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
